// File: rtl/ahb_grant.sv
// ahb_grant: grant generator for the 5-master AHB arbiter.
// Resolves hbusreq against the ordered priority list, registers a one-hot
// grant, holds it across fixed-length bursts and locked sequences, and
// tracks address-phase ownership on hmaster/hmastlock.
module ahb_grant #(
  parameter int NM = 5
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [NM-1:0]    hbusreq,
  input  logic [NM-1:0]    hlock,
  input  logic [NM*NM-1:0] priout,
  input  logic             hready,
  input  logic [1:0]       htrans,
  input  logic [2:0]       hburst,
  output logic [NM-1:0]    hgrant,
  output logic [2:0]       hmaster,
  output logic             hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [NM-1:0] DEFAULT_GRANT = {{(NM-1){1'b0}}, 1'b1};

  logic [NM-1:0] hgrant_q,    hgrant_d;
  logic [2:0]    hmaster_q,   hmaster_d;
  logic          hmastlock_q, hmastlock_d;
  logic [3:0]    cnt_q,       cnt_d;

  logic [NM-1:0] field [NM];
  logic [NM-1:0] next_grant;
  logic [2:0]    grant_idx;
  logic          lock_hold;
  logic          burst_hold;
  logic          arb_en;

  // Split the flat list into fields; field[NM-1] is the highest priority.
  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_field
      assign field[gi] = priout[gi*NM +: NM];
    end
  endgenerate

  // Winner selection: first field (highest first) that hits a request, else M0.
  always_comb begin
    logic found;
    next_grant = DEFAULT_GRANT;
    found      = 1'b0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (!found && (|(field[i] & hbusreq))) begin
        next_grant = field[i];
        found      = 1'b1;
      end
    end
  end

  // Binary index of the current one-hot grant, used for hmaster.
  always_comb begin
    grant_idx = 3'd0;
    for (int i = 0; i < NM; i++) begin
      if (hgrant_q[i]) begin
        grant_idx = 3'(i);
      end
    end
  end

  // Beat counter: loaded on NONSEQ by burst length, counts SEQ beats down,
  // cleared on IDLE (early termination), held on BUSY or while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (hready) begin
      case (htrans)
        TR_NONSEQ: begin
          case (hburst)
            3'b010, 3'b011: cnt_d = 4'd3;
            3'b100, 3'b101: cnt_d = 4'd7;
            3'b110, 3'b111: cnt_d = 4'd15;
            default:        cnt_d = 4'd0;
          endcase
        end
        TR_SEQ: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        TR_IDLE: cnt_d = 4'd0;
        TR_BUSY: cnt_d = cnt_q;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Hold conditions and next-state for grant and ownership. The last SEQ beat
  // (cnt=1, SEQ) releases the hold so the next owner can start back-to-back.
  always_comb begin
    lock_hold  = |(hlock & hgrant_q);
    burst_hold = (cnt_q > 4'd1)
               || ((cnt_q == 4'd1) && (htrans != TR_SEQ))
               || ((htrans == TR_NONSEQ) && (hburst[2:1] != 2'b00));
    arb_en     = hready && !lock_hold && !burst_hold;

    hgrant_d    = arb_en ? next_grant : hgrant_q;
    hmaster_d   = hready ? grant_idx  : hmaster_q;
    hmastlock_d = hready ? lock_hold  : hmastlock_q;
  end

  // State registers with synchronous active-low reset; reset drops any hold.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      hgrant_q    <= DEFAULT_GRANT;
      hmaster_q   <= 3'd0;
      hmastlock_q <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_grant.sv
// tb_ahb_grant: vector table plus hand-written burst/lock sequences; expected
// outputs are queued when a vector is driven and checked after the edge.
module tb_ahb_grant;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] NSQ  = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] INCR16 = 3'b111;

  // P0 order: M0, M2, M3, M4, M1.  P1 order: M4, M3, M2, M1, M0.
  localparam logic [24:0] P0 = 25'b00001_00100_01000_10000_00010;
  localparam logic [24:0] P1 = 25'b10000_01000_00100_00010_00001;

  logic        hclk;
  logic        hresetn;
  logic [4:0]  hbusreq;
  logic [4:0]  hlock;
  logic [24:0] priout;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [4:0]  hgrant;
  logic [2:0]  hmaster;
  logic        hmastlock;

  ahb_grant #(.NM(5)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .priout    (priout),
    .hready    (hready),
    .htrans    (htrans),
    .hburst    (hburst),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        rstn;
    logic [4:0]  req;
    logic [4:0]  lock;
    logic [24:0] pri;
    logic        rdy;
    logic [1:0]  tr;
    logic [2:0]  bu;
    logic [4:0]  eg;
    logic [2:0]  em;
    logic        el;
    string       name;
  } vec_t;

  typedef struct {
    logic [4:0] g;
    logic [2:0] m;
    logic       l;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rstn, input logic [4:0] req, input logic [4:0] lock,
                              input logic [24:0] pri, input logic rdy, input logic [1:0] tr,
                              input logic [2:0] bu, input logic [4:0] eg, input logic [2:0] em,
                              input logic el, input string name);
    vec_t v;
    v.rstn = rstn; v.req = req; v.lock = lock; v.pri = pri; v.rdy = rdy;
    v.tr = tr; v.bu = bu; v.eg = eg; v.em = em; v.el = el; v.name = name;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    hresetn = v.rstn; hbusreq = v.req; hlock = v.lock; priout = v.pri;
    hready = v.rdy; htrans = v.tr; hburst = v.bu;
    e.g = v.eg; e.m = v.em; e.l = v.el; e.name = v.name;
    sb_q.push_back(e);
    @(posedge hclk);
    #1;
    e = sb_q.pop_front();
    check({e.name, ".hgrant"},    int'(hgrant),    int'(e.g));
    check({e.name, ".hmaster"},   int'(hmaster),   int'(e.m));
    check({e.name, ".hmastlock"}, int'(hmastlock), int'(e.l));
    $display("step %-10s req=%b lock=%b rdy=%b tr=%b bu=%b -> hgrant=%b hmaster=%0d hmastlock=%b",
             e.name, v.req, v.lock, v.rdy, v.tr, v.bu, hgrant, hmaster, hmastlock);
  endtask

  // Hand-sequence shorthand: out of reset, list P0, all fields explicit.
  task automatic run(input logic [4:0] req, input logic [4:0] lock, input logic rdy,
                     input logic [1:0] tr, input logic [2:0] bu,
                     input logic [4:0] eg, input logic [2:0] em, input logic el,
                     input string name);
    apply(mk(1'b1, req, lock, P0, rdy, tr, bu, eg, em, el, name));
  endtask

  vec_t tbl[20];

  initial begin
    // Reset, priority order, default master, stall freeze, lock in the table.
    tbl[0]  = mk(0, 5'b11111, 5'b11111, P0, 1, IDLE, SINGLE, 5'b00001, 3'd0, 0, "rst0");
    tbl[1]  = mk(0, 5'b11111, 5'b11111, P0, 1, IDLE, SINGLE, 5'b00001, 3'd0, 0, "rst1");
    tbl[2]  = mk(1, 5'b00000, 5'b00000, P0, 1, IDLE, SINGLE, 5'b00001, 3'd0, 0, "rel0");
    tbl[3]  = mk(1, 5'b00000, 5'b00000, P0, 1, IDLE, SINGLE, 5'b00001, 3'd0, 0, "rel1");
    tbl[4]  = mk(1, 5'b10110, 5'b00000, P0, 1, IDLE, SINGLE, 5'b00100, 3'd0, 0, "pri_m2");
    tbl[5]  = mk(1, 5'b10110, 5'b00000, P0, 1, IDLE, SINGLE, 5'b00100, 3'd2, 0, "pri_m2b");
    // M2 dropped, M3 idle, so M4 is next in the list ahead of M1.
    tbl[6]  = mk(1, 5'b10010, 5'b00000, P0, 1, IDLE, SINGLE, 5'b10000, 3'd2, 0, "pri_m4");
    tbl[7]  = mk(1, 5'b10010, 5'b00000, P0, 1, IDLE, SINGLE, 5'b10000, 3'd4, 0, "pri_m4b");
    tbl[8]  = mk(1, 5'b00110, 5'b00000, P1, 1, IDLE, SINGLE, 5'b00100, 3'd4, 0, "p1_m2");
    tbl[9]  = mk(1, 5'b00011, 5'b00000, P1, 1, IDLE, SINGLE, 5'b00010, 3'd2, 0, "p1_m1");
    tbl[10] = mk(1, 5'b00000, 5'b00000, P1, 1, IDLE, SINGLE, 5'b00001, 3'd1, 0, "dflt0");
    tbl[11] = mk(1, 5'b00000, 5'b00000, P1, 1, IDLE, SINGLE, 5'b00001, 3'd0, 0, "dflt1");
    tbl[12] = mk(1, 5'b01000, 5'b00000, P1, 0, IDLE, SINGLE, 5'b00001, 3'd0, 0, "stall_g");
    tbl[13] = mk(1, 5'b01000, 5'b00000, P1, 1, IDLE, SINGLE, 5'b01000, 3'd0, 0, "go_m3");
    tbl[14] = mk(1, 5'b01000, 5'b00000, P1, 0, IDLE, SINGLE, 5'b01000, 3'd0, 0, "stall_m");
    tbl[15] = mk(1, 5'b01000, 5'b00000, P1, 1, IDLE, SINGLE, 5'b01000, 3'd3, 0, "own_m3");
    tbl[16] = mk(1, 5'b10000, 5'b01000, P1, 1, IDLE, SINGLE, 5'b01000, 3'd3, 1, "lk_m3");
    tbl[17] = mk(1, 5'b10000, 5'b00000, P1, 1, IDLE, SINGLE, 5'b10000, 3'd3, 0, "unlk_m3");
    tbl[18] = mk(1, 5'b10000, 5'b10000, P1, 1, IDLE, SINGLE, 5'b10000, 3'd4, 1, "lk_m4");
    tbl[19] = mk(1, 5'b00001, 5'b00000, P1, 1, IDLE, SINGLE, 5'b00001, 3'd4, 0, "unlk_m4");

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // INCR4 by M1 with M3 pending: handover on the 3rd SEQ beat.
    run(5'b00010, 5'b0, 1, IDLE, SINGLE, 5'b00010, 3'd0, 0, "i4_own");
    run(5'b01010, 5'b0, 1, NSQ,  INCR4,  5'b00010, 3'd1, 0, "i4_ns");
    run(5'b01010, 5'b0, 1, SEQ,  INCR4,  5'b00010, 3'd1, 0, "i4_s1");
    run(5'b01010, 5'b0, 1, SEQ,  INCR4,  5'b00010, 3'd1, 0, "i4_s2");
    run(5'b01010, 5'b0, 1, SEQ,  INCR4,  5'b01000, 3'd1, 0, "i4_s3");
    run(5'b01000, 5'b0, 1, IDLE, SINGLE, 5'b01000, 3'd3, 0, "i4_post");

    // Same burst with a wait state on beat 2: handover one cycle later.
    run(5'b00010, 5'b0, 1, IDLE, SINGLE, 5'b00010, 3'd3, 0, "w4_own");
    run(5'b01010, 5'b0, 1, NSQ,  INCR4,  5'b00010, 3'd1, 0, "w4_ns");
    run(5'b01010, 5'b0, 0, SEQ,  INCR4,  5'b00010, 3'd1, 0, "w4_wait");
    run(5'b01010, 5'b0, 1, SEQ,  INCR4,  5'b00010, 3'd1, 0, "w4_s1");
    run(5'b01010, 5'b0, 1, SEQ,  INCR4,  5'b00010, 3'd1, 0, "w4_s2");
    run(5'b01010, 5'b0, 1, SEQ,  INCR4,  5'b01000, 3'd1, 0, "w4_s3");

    // INCR8 terminated early by IDLE: grant moves on the following edge.
    run(5'b00010, 5'b0, 1, IDLE, SINGLE, 5'b00010, 3'd3, 0, "i8_own");
    run(5'b01010, 5'b0, 1, NSQ,  INCR8,  5'b00010, 3'd1, 0, "i8_ns");
    run(5'b01010, 5'b0, 1, SEQ,  INCR8,  5'b00010, 3'd1, 0, "i8_s1");
    run(5'b01010, 5'b0, 1, IDLE, INCR8,  5'b00010, 3'd1, 0, "i8_idle");
    run(5'b01010, 5'b0, 1, IDLE, SINGLE, 5'b01000, 3'd1, 0, "i8_move");
    run(5'b01000, 5'b0, 1, IDLE, SINGLE, 5'b01000, 3'd3, 0, "i8_post");

    // Undefined-length INCR does not hold; then all requests drop.
    run(5'b01100, 5'b0, 1, NSQ,  INCR,   5'b00100, 3'd3, 0, "incr_arb");
    run(5'b00000, 5'b0, 1, IDLE, SINGLE, 5'b00001, 3'd2, 0, "dflt_m0");

    // Locked sequence by M4 while M0 (top priority) requests.
    run(5'b10000, 5'b00000, 1, IDLE, SINGLE, 5'b10000, 3'd0, 0, "lk_own");
    for (int i = 0; i < 6; i++)
      run(5'b10001, 5'b10000, 1, IDLE, SINGLE, 5'b10000, 3'd4, 1, $sformatf("lk_hold%0d", i));
    run(5'b10001, 5'b00000, 0, IDLE, SINGLE, 5'b10000, 3'd4, 1, "lk_stall");
    run(5'b00001, 5'b00000, 1, IDLE, SINGLE, 5'b00001, 3'd4, 0, "lk_drop");
    run(5'b00001, 5'b00000, 1, IDLE, SINGLE, 5'b00001, 3'd0, 0, "lk_post");

    // Reset in the middle of an INCR16 abandons the hold.
    run(5'b00010, 5'b0, 1, IDLE, SINGLE, 5'b00010, 3'd0, 0, "r16_own");
    run(5'b01010, 5'b0, 1, NSQ,  INCR16, 5'b00010, 3'd1, 0, "r16_ns");
    apply(mk(0, 5'b01010, 5'b0, P0, 1, SEQ, INCR16, 5'b00001, 3'd0, 0, "r16_rst"));
    run(5'b01010, 5'b0, 1, IDLE, SINGLE, 5'b01000, 3'd0, 0, "r16_arb");

    // WRAP4 with BUSY at the last beat keeps the grant until the SEQ.
    run(5'b00010, 5'b0, 1, IDLE, SINGLE, 5'b00010, 3'd3, 0, "bz_own");
    run(5'b01010, 5'b0, 1, NSQ,  WRAP4,  5'b00010, 3'd1, 0, "bz_ns");
    run(5'b01010, 5'b0, 1, SEQ,  WRAP4,  5'b00010, 3'd1, 0, "bz_s1");
    run(5'b01010, 5'b0, 1, SEQ,  WRAP4,  5'b00010, 3'd1, 0, "bz_s2");
    run(5'b01010, 5'b0, 1, BUSY, WRAP4,  5'b00010, 3'd1, 0, "bz_busy");
    run(5'b01010, 5'b0, 1, SEQ,  WRAP4,  5'b01000, 3'd1, 0, "bz_s3");

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
